// File: rtl/mw93_pkg.sv
// mw93_pkg: opcodes, state encoding and default sizes for the Microwire responder
package mw93_pkg;
  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 16;
  localparam int WR_BUSY_DEF = 16;
  localparam logic [1:0] OP_EXT = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ = 2'b10;
  localparam logic [1:0] OP_ERASE = 2'b11;
  localparam logic [1:0] EX_EWDS = 2'b00;
  localparam logic [1:0] EX_WRAL = 2'b01;
  localparam logic [1:0] EX_ERAL = 2'b10;
  localparam logic [1:0] EX_EWEN = 2'b11;
  typedef enum logic [2:0] {IDLE, OPCODE, ADDR, RD_DATA, WR_DATA, WAIT_CSL, PROG} state_t;
endpackage

// File: rtl/mw93_sync.sv
// mw93_sync: 2-flop synchronizer with rise/fall detect on the synced level
module mw93_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);
  logic [W-1:0] s1, s2, s3;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1, s2, s3} <= '0;
    else {s1, s2, s3} <= {d, s1, s2};
  assign q = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
endmodule

// File: rtl/mw93_responder.sv
// mw93_responder: 93C46-style Microwire slave serving reads/writes from an external word RAM
module mw93_responder
  import mw93_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int WR_BUSY_CYCLES = WR_BUSY_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_i,
  input  logic              sk_i,
  input  logic              di_i,
  output logic              do_o,
  output logic              do_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy_o
);
  localparam int CNT_W = $clog2(ADDR_W + DATA_W + 1);
  localparam int PC_W = $clog2((1 << ADDR_W) + WR_BUSY_CYCLES + 1);
  state_t state, nstate, addr_done;
  logic cs_q, cs_rise, cs_fall, sk_q, sk_rise, sk_fall, di_q, di_rise, di_fall;
  logic unused_sync;
  logic sk_up, last, bulk_op;
  logic [CNT_W-1:0] cnt;
  logic [1:0] op, ext;
  logic [ADDR_W-1:0] addr_q, a_nxt;
  logic [DATA_W-1:0] sh, wdata_q;
  logic wel, bulk, req, rdy, rd_q, rd_d, dout_q;
  logic [PC_W-1:0] pcnt, wr_n, prog_end;
  mw93_sync u_cs (.clk(clk), .rst_n(rst_n), .d(cs_i), .q(cs_q), .rise(cs_rise), .fall(cs_fall));
  mw93_sync u_sk (.clk(clk), .rst_n(rst_n), .d(sk_i), .q(sk_q), .rise(sk_rise), .fall(sk_fall));
  mw93_sync u_di (.clk(clk), .rst_n(rst_n), .d(di_i), .q(di_q), .rise(di_rise), .fall(di_fall));
  assign unused_sync = ^{cs_rise, sk_q, sk_fall, di_rise, di_fall};
  assign sk_up = sk_rise & cs_q;
  assign a_nxt = {addr_q[ADDR_W-2:0], di_q};
  assign ext = a_nxt[ADDR_W-1 -: 2];
  assign bulk_op = op == OP_EXT && (ext == EX_ERAL || ext == EX_WRAL);
  assign last = (state == OPCODE) ? cnt == CNT_W'(1) :
                (state == ADDR) ? cnt == CNT_W'(ADDR_W - 1) : cnt == CNT_W'(DATA_W - 1);
  assign addr_done = (op == OP_READ) ? RD_DATA :
                     (op == OP_WRITE || (op == OP_EXT && ext == EX_WRAL)) ? WR_DATA : WAIT_CSL;
  assign wr_n = bulk ? PC_W'(1 << ADDR_W) : PC_W'(1);
  assign prog_end = wr_n + PC_W'(WR_BUSY_CYCLES) - PC_W'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nstate;
  always_comb begin
    nstate = state;
    if (state == PROG)
      nstate = (pcnt == prog_end) ? IDLE : PROG;
    else if (cs_fall)
      nstate = (state == WAIT_CSL && req && wel) ? PROG : IDLE;
    else if (sk_up)
      nstate = (state == IDLE && di_q) ? OPCODE :
               (state == OPCODE && last) ? ADDR :
               (state == ADDR && last) ? addr_done :
               (state == WR_DATA && last) ? WAIT_CSL : state;
  end
  always_comb begin
    do_o = (state == RD_DATA) ? dout_q : (state == IDLE) && rdy;
    busy_o = state == PROG;
    mem_wr_en = state == PROG && pcnt < wr_n;
    mem_addr = (state == PROG && bulk) ? pcnt[ADDR_W-1:0] : addr_q;
  end
  assign do_oe = cs_q;
  assign mem_rd_en = rd_q;
  assign mem_wdata = wdata_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      op <= '0;
      addr_q <= '0;
      sh <= '0;
      wdata_q <= '0;
      dout_q <= 1'b0;
      wel <= 1'b0;
      bulk <= 1'b0;
      req <= 1'b0;
      rdy <= 1'b0;
      rd_q <= 1'b0;
      rd_d <= 1'b0;
      pcnt <= '0;
    end else begin
      rd_q <= 1'b0;
      rd_d <= rd_q;
      pcnt <= (state == PROG) ? pcnt + PC_W'(1) : '0;
      if (rd_d) sh <= mem_rdata;
      if (state == PROG && nstate == IDLE) rdy <= 1'b1;
      if (sk_up) begin
        cnt <= (state == IDLE || last) ? '0 : cnt + CNT_W'(1);
        case (state)
          IDLE: rdy <= rdy & ~di_q;
          OPCODE: op <= {op[0], di_q};
          ADDR: begin
            addr_q <= a_nxt;
            if (last) begin
              rd_q <= op == OP_READ;
              dout_q <= 1'b0;
              bulk <= op == OP_EXT;
              req <= op == OP_WRITE || op == OP_ERASE || bulk_op;
              wdata_q <= (op == OP_ERASE || op == OP_EXT) ? '1 : wdata_q;
              wel <= (op != OP_EXT) ? wel : (ext == EX_EWEN) ? 1'b1 : (ext == EX_EWDS) ? 1'b0 : wel;
            end
          end
          RD_DATA: begin
            dout_q <= sh[DATA_W-1];
            sh <= sh << 1;
            if (last) begin
              addr_q <= addr_q + ADDR_W'(1);
              rd_q <= 1'b1;
            end
          end
          WR_DATA: wdata_q <= {wdata_q[DATA_W-2:0], di_q};
          default: ;
        endcase
      end
    end
endmodule
